// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32I decode/issue slice: datapath width, the
// two supported major opcodes, funct3 codes and the 3-bit ALU control
// encoding understood by the downstream ALU.
// Helper: alu_ctrl_of() maps funct3 plus the instr[30] "alternate" bit to an
// ALU control code.
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    // alt is instr[30]; the caller masks it for encodings where it is
    // not meaningful (e.g. ADDI, whose immediate occupies bit 30).
    function automatic logic [2:0] alu_ctrl_of(input logic [2:0] funct3,
                                               input logic       alt);
        logic [2:0] ctrl;
        ctrl = ALU_ADD;
        case (funct3)
            F3_ADD:  ctrl = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  ctrl = ALU_SLL;
            F3_XOR:  ctrl = ALU_XOR;
            F3_SRL:  ctrl = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   ctrl = ALU_OR;
            F3_AND:  ctrl = ALU_AND;
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// -----------------------------------------------------------------------------
// rv_regfile
// Integer register file: two combinational read ports, one write port.
// x0 always reads zero and writes to it are dropped. All registers clear on
// asynchronous active-low reset.
// Ports:
//   clk, rst_n             clock / async active-low reset
//   rs1_addr, rs1_data     read port 1
//   rs2_addr, rs2_data     read port 2
//   we, wr_addr, wr_data   write port (takes effect on rising clk edge)
// -----------------------------------------------------------------------------
module rv_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs_reg [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs_reg[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs_reg[rs2_addr];

endmodule

// File: rtl/rv_decode_issue.sv
// -----------------------------------------------------------------------------
// rv_decode_issue
// Decode / operand-fetch stage for the RV32I teaching core. Accepts OP and
// OP-IMM instructions, reads rs1/rs2 from the register file, and presents
// ALU ctrl, operands and rd through a single output register. A pending-bit
// scoreboard stalls any instruction whose sources or destination are still
// awaiting writeback.
//
// Build option: define RV_DECODE_BYPASS_EN to let a writeback arriving in the
// current cycle release the hazard and forward wb_data into the operands.
// Without it, the stalled instruction issues the cycle after writeback.
//
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready, in_instr    instruction input handshake
//   out_valid, out_ready            output handshake toward the ALU
//   out_ctrl, out_a, out_b, out_rd  decoded operation
//   out_illegal                     unsupported instruction marker
//   wb_en, wb_rd, wb_data           writeback from downstream
// -----------------------------------------------------------------------------
module rv_decode_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_ctrl,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    import rv_pkg::*;

    // ---------------------------------------------------------------- decode
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       alt;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign alt    = in_instr[30];

    logic       is_op;
    logic       is_op_imm;
    logic       is_shift;
    logic       legal;
    logic [2:0] ctrl_dec;

    always_comb begin
        is_op     = (opcode == OP);
        is_op_imm = (opcode == OP_IMM);
        is_shift  = (funct3 == F3_SLL) || (funct3 == F3_SRL);
        legal     = (is_op || is_op_imm) &&
                    (funct3 != F3_SLT) && (funct3 != F3_SLTU);
        // For OP-IMM, bit 30 only selects SRAI; elsewhere it is immediate data.
        if (is_op) begin
            ctrl_dec = alu_ctrl_of(funct3, alt);
        end else begin
            ctrl_dec = alu_ctrl_of(funct3, alt && (funct3 == F3_SRL));
        end
    end

    // --------------------------------------------------------- register file
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (5)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1),
        .rs1_data (rs1_rf),
        .rs2_addr (rs2),
        .rs2_data (rs2_rf),
        .we       (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // ------------------------------------------------------------ scoreboard
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] pending_eff;
    logic [NREG-1:0] wb_onehot;
    logic [NREG-1:0] set_onehot;
    logic            accept;

    // x0 is never marked pending, so bit 0 of set_onehot stays zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        assign wb_onehot[gi] = wb_en && (wb_rd == 5'(gi));
        if (gi == 0) begin : g_x0
            assign set_onehot[gi] = 1'b0;
        end else begin : g_xn
            assign set_onehot[gi] = accept && legal && (rd == 5'(gi));
        end
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    assign pending_next = (pending_reg & ~wb_onehot) | set_onehot;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

`ifdef RV_DECODE_BYPASS_EN
    // A writeback landing this cycle releases its register immediately and
    // supplies the operand directly, ahead of the register file update.
    assign pending_eff = pending_reg & ~wb_onehot;
    assign rs1_val = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rs1_rf;
    assign rs2_val = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rs2_rf;
`else
    assign pending_eff = pending_reg;
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    // Illegal instructions never stall; rs2 only matters for R-type.
    logic hazard;
    assign hazard = legal &&
                    (pending_eff[rs1] || (is_op && pending_eff[rs2]) || pending_eff[rd]);

    logic valid_reg;
    assign in_ready = (!valid_reg || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // --------------------------------------------------------------- operand b
    logic [XLEN-1:0] b_dec;
    always_comb begin
        if (is_op) begin
            b_dec = rs2_val;
        end else if (is_shift) begin
            b_dec = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        end else begin
            b_dec = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        end
    end

    // --------------------------------------------------------- output register
    logic [2:0]      ctrl_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [4:0]      rd_reg;
    logic            illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= ALU_ADD;
            a_reg       <= '0;
            b_reg       <= '0;
            rd_reg      <= '0;
            illegal_reg <= 1'b0;
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
            if (accept) begin
                valid_reg <= 1'b1;
                if (legal) begin
                    ctrl_reg    <= ctrl_dec;
                    a_reg       <= rs1_val;
                    b_reg       <= b_dec;
                    rd_reg      <= rd;
                    illegal_reg <= 1'b0;
                end else begin
                    ctrl_reg    <= ALU_ADD;
                    a_reg       <= '0;
                    b_reg       <= '0;
                    rd_reg      <= '0;
                    illegal_reg <= 1'b1;
                end
            end else if (out_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_reg;
    assign out_ctrl    = ctrl_reg;
    assign out_a       = a_reg;
    assign out_b       = b_reg;
    assign out_rd      = rd_reg;
    assign out_illegal = illegal_reg;

endmodule

// File: doc/rv_decode_issue.md
Name: rv_decode_issue

Overview:
- Decode/operand-fetch stage for the RV32I teaching core; sits directly upstream of the 3-bit-ctrl ALU.
- Accepts OP and OP-IMM instructions over valid/ready and reads the integer register file.
- Emits ALU ctrl, operand a, operand b and destination rd through one output register.
- Takes writeback from downstream and tracks pending destinations in a scoreboard to stall RAW/WAW hazards.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction available.
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
- in_instr  in  32  RV32I instruction word.
- out_valid  out  1  decoded operation held in output register.
- out_ready  in  1  ALU stage consumes when out_valid & out_ready.
- out_ctrl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- out_a  out  XLEN  operand a (rs1 value).
- out_b  out  XLEN  operand b (rs2 value or sign-extended imm).
- out_rd  out  5  destination register.
- out_illegal  out  1  unsupported instruction marker.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback value.

Behaviour:
- Reset: out_valid=0, out_ctrl=000, out_a=0, out_b=0, out_rd=0, out_illegal=0, all pending bits=0, all registers=0. Reset mid-operation drops the held op.
- Decode, opcode 0110011 (R-type), by funct3:
  - 000: ctrl 000, or 001 when instr[30]=1.
  - 111: ctrl 010. 110: ctrl 011. 100: ctrl 100. 001: ctrl 101.
  - 101: ctrl 110, or 111 when instr[30]=1.
  - b = rs2 value.
- Decode, opcode 0010011 (I-type): same funct3 map.
  - funct3 000 is always ctrl 000; instr[30] is ignored for ADDI.
  - b = sign-extended instr[31:20], except shifts: b = zero-extended instr[24:20], with SRAI selected by instr[30].
- Illegal: any other opcode, or funct3 010/011 (SLT/SLTU).
  - Output out_illegal=1, ctrl=000, a=0, b=0, rd=0.
  - Never stalls; never sets pending.
- Hazard: stall if any used source (rs1; plus rs2 for R-type) or rd is pending. Register x0 is never pending.
- in_ready = (!out_valid | out_ready) & !hazard. in_ready is combinational from in_instr and the scoreboard.
- Latency: accepted instruction appears on out_* the next cycle. Throughput is 1 per cycle with no hazard.
- Scoreboard:
  - On accept with rd != 0 and legal, set pending[rd].
  - On wb_en, clear pending[wb_rd].
  - Same cycle set and clear of the same index: set wins.
  - wb_en with wb_rd not pending is still written to the register file.
- Register file:
  - Written on the clk edge when wb_en & wb_rd != 0; writes to x0 are discarded.
  - Read is combinational.
- out_* hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: RV_DECODE_BYPASS_EN.
- Defined:
  - A source whose pending bit is cleared by wb_en in the current cycle is not a hazard.
  - The operand is taken from wb_data that same cycle.
  - rd hazard is likewise released by a matching wb.
- Undefined:
  - Hazard uses the registered pending bits only.
  - The instruction issues one cycle after writeback and reads the updated register file.

Decomposition:
- Shared package rv_pkg: opcode constants OP=0110011, OP_IMM=0010011; ALU ctrl localparams ALU_ADD..ALU_SRA matching the encoding above; XLEN.
- One sub-module rv_regfile: 2 combinational read ports, 1 write port, x0 zero, async active-low reset.

Test Plan:
- Reset: rst_n low mid-stream → out_valid=0 and in_ready=1 after release; x1..x31 read 0.
- ADDI x1,x0,-5 (0xFFB00093) → next cycle ctrl=000, a=0, b=0xFFFFFFFB, rd=1.
  - Then wb x1=0xFFFFFFFB.
  - Then SRAI x2,x1,2 → ctrl=111, a=0xFFFFFFFB, b=2.
- RAW stall: issue ADD x3,x1,x2 with x1 pending → in_ready=0 until wb x1.
  - With RV_DECODE_BYPASS_EN: issues in the wb cycle with a=wb_data.
  - Without it: issues one cycle later.
- Backpressure: out_ready=0 for 3 cycles with SUB x4,x5,x6 held → out_* unchanged, in_ready=0; one out_ready pulse → next op loads.
- Illegal: SLT x7,x1,x2 (funct3 010) → out_illegal=1, ctrl=000, rd=0, no stall, pending[7] stays 0.
- Simultaneous set/clear: wb x8 in the same cycle as accepting ADDI x8,x0,1 → pending[8]=1 afterward; a following ADD x9,x8,x0 stalls.
